pwm_button_conditioner: RTL and testbench
=========================================

Name: pwm_button_conditioner

Overview:
- Upstream stage of the PWM duty-cycle controller.
- Takes the two raw push-button inputs (increase, decrease) and synchronises and debounces them.
- Converts each press into single-cycle step pulses, with hold-to-auto-repeat.
- The duty register downstream consumes inc_pulse/dec_pulse directly; one pulse means one duty step.

Parameters:
- TICK_DIV, 4: clk cycles per debounce/repeat tick (set about 250000 on FPGA; small for simulation); must be >=2.
- DEBOUNCE_TICKS, 3: consecutive ticks of a stable new level required before the debounced level changes; >=1.
- REPEAT_DELAY_TICKS, 8: ticks a button must stay held after the first pulse before auto-repeat begins; >=1.
- REPEAT_RATE_TICKS, 2: ticks between auto-repeat pulses; >=1.
- CNT_W, 16: width of the tick and hold counters; must hold max(TICK_DIV, REPEAT_DELAY_TICKS).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable; low freezes the tick prescaler and suppresses all pulses
- btn_inc_raw  input  1  raw increase button, asynchronous, active-high
- btn_dec_raw  input  1  raw decrease button, asynchronous, active-high
- inc_level  output  1  debounced increase-button level
- dec_level  output  1  debounced decrease-button level
- inc_pulse  output  1  one-cycle increase step request
- dec_pulse  output  1  one-cycle decrease step request

Behaviour:
- Reset (rst_n low, async): all flops cleared.
  - Synchronisers, prescaler, debounce counters and hold counters = 0.
  - FSMs go to IDLE.
  - inc_level = dec_level = inc_pulse = dec_pulse = 0.
- Synchroniser: 2-FF per button. The sync output lags the raw input by 2 clk.
- Prescaler:
  - tick_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (tick_cnt == TICK_DIV-1), combinational, high for 1 cycle in every TICK_DIV.
  - When en=0, tick_cnt holds its value and tick is forced 0.
- Debounce (per button):
  - Any cycle with sync == level: db_cnt <= 0.
  - On a tick with sync != level: if db_cnt == DEBOUNCE_TICKS-1, then level <= sync and db_cnt <= 0; else db_cnt increments.
  - A glitch that reverts before the DEBOUNCE_TICKS-th mismatching tick never changes level.
- Step FSM (per button), states IDLE, HOLD, REPEAT; hold_cnt is cleared on every state entry.
  - IDLE: level rising -> emit pulse, go to HOLD.
  - HOLD: on tick, hold_cnt increments. On the tick where hold_cnt == REPEAT_DELAY_TICKS-1 -> emit pulse, go to REPEAT.
  - REPEAT: on tick, hold_cnt increments. On the tick where hold_cnt == REPEAT_RATE_TICKS-1 -> emit pulse, hold_cnt <= 0.
  - Any state, level == 0 -> IDLE, no pulse. Release has priority over a same-cycle repeat pulse.
- Pulse outputs are registered: high exactly 1 cycle, in the cycle after the emitting event. No output ever stays high 2 consecutive cycles.
- Conflict rule:
  - inc_pulse = emitted_inc AND NOT dec_level; dec_pulse = emitted_dec AND NOT inc_level (levels sampled in the emit cycle).
  - Both buttons held -> no pulses. Both FSMs keep running, so releasing one resumes the other's repeat cadence without re-triggering a first pulse.
- en=0: pulses are forced 0 and ticks stop, so debounce and hold counters freeze. Synchronisers keep running.
- Reset asserted mid-hold: everything clears immediately. After release, a still-pressed button is treated as a new press once debounced.
- Latency: raw rise to first pulse = 2 clk (sync) + time to the DEBOUNCE_TICKS-th tick + 1 clk.

Test Plan:
- Reset/idle: hold rst_n=0 with both buttons high, then release, en=1 -> all outputs 0 during reset; inc_level rises on the 3rd tick after sync; inc_pulse is a single cycle the clk after that.
- Glitch rejection: btn_inc_raw high for 6 clk (spans under 3 ticks), then low -> inc_level stays 0, no inc_pulse; db_cnt returns to 0.
- Auto-repeat: hold btn_dec_raw for 60 ticks -> first dec_pulse, then the next one 8 ticks later, then one every 2 ticks. Pulse count matches 1 + 1 + floor((60-3-8)/2) within ±1 edge; each pulse is exactly 1 cycle.
- Release mid-repeat: release on the cycle a repeat pulse would fire -> no pulse. dec_level falls after 3 ticks; FSM returns to IDLE and emits nothing further.
- Conflict: hold inc, then press dec 5 ticks later -> no dec_pulse while inc_level=1 and inc repeats suppressed. Release inc -> dec repeats resume every 2 ticks, with no extra first pulse.
- Enable gating: drop en to 0 for 20 clk mid-HOLD -> no pulses and counters frozen. Restore en -> the repeat delay completes the remaining ticks, with no lost or duplicated pulse.

Source files
------------

// File: rtl/pwm_button_conditioner.sv
// Button front end for the PWM duty controller: 2-FF sync, tick-based debounce,
// press-to-step pulses with hold-to-auto-repeat. Index 0 = increase, 1 = decrease.
module pwm_button_conditioner #(
   parameter int TICK_DIV           = 4,
   parameter int DEBOUNCE_TICKS     = 3,
   parameter int REPEAT_DELAY_TICKS = 8,
   parameter int REPEAT_RATE_TICKS  = 2,
   parameter int CNT_W              = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic btn_inc_raw,
   input  logic btn_dec_raw,
   output logic inc_level,
   output logic dec_level,
   output logic inc_pulse,
   output logic dec_pulse
);

   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} state_e;

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
   localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(REPEAT_DELAY_TICKS - 1);
   localparam logic [CNT_W-1:0] RR_LAST   = CNT_W'(REPEAT_RATE_TICKS - 1);

   logic [1:0]       raw_s;
   logic [1:0]       sync1_q, sync2_q;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             tick_s;
   logic [1:0]       level_q, level_d;
   logic [CNT_W-1:0] db_cnt_q [2];
   logic [CNT_W-1:0] db_cnt_d [2];
   logic [CNT_W-1:0] hold_cnt_q [2];
   logic [CNT_W-1:0] hold_cnt_d [2];
   state_e           state_q [2];
   state_e           state_d [2];
   logic [1:0]       emit_s;
   logic [1:0]       pulse_q, pulse_d;

   assign raw_s = {btn_dec_raw, btn_inc_raw};

   // Tick prescaler; frozen while disabled so every tick-based counter freezes too.
   always_comb begin
      tick_s     = en && (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick_cnt_q;
      if (!en) begin
         tick_cnt_d = tick_cnt_q;
      end else if (tick_s) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         level_d[i]  = level_q[i];
         db_cnt_d[i] = db_cnt_q[i];
         if (sync2_q[i] == level_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (tick_s) begin
            if (db_cnt_q[i] == DB_LAST) begin
               level_d[i]  = sync2_q[i];
               db_cnt_d[i] = '0;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
            end
         end else begin
            db_cnt_d[i] = db_cnt_q[i];
         end
      end
   end

   // Step FSMs: a low level always wins, so release beats a same-cycle repeat.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_d[i]    = state_q[i];
         hold_cnt_d[i] = hold_cnt_q[i];
         emit_s[i]     = 1'b0;
         if (!level_q[i]) begin
            state_d[i]    = IDLE;
            hold_cnt_d[i] = '0;
         end else begin
            case (state_q[i])
               IDLE: begin
                  emit_s[i]     = 1'b1;
                  state_d[i]    = HOLD;
                  hold_cnt_d[i] = '0;
               end
               HOLD: begin
                  if (!tick_s) begin
                     hold_cnt_d[i] = hold_cnt_q[i];
                  end else if (hold_cnt_q[i] == RD_LAST) begin
                     emit_s[i]     = 1'b1;
                     state_d[i]    = REPEAT;
                     hold_cnt_d[i] = '0;
                  end else begin
                     hold_cnt_d[i] = hold_cnt_q[i] + CNT_W'(1);
                  end
               end
               REPEAT: begin
                  if (!tick_s) begin
                     hold_cnt_d[i] = hold_cnt_q[i];
                  end else if (hold_cnt_q[i] == RR_LAST) begin
                     emit_s[i]     = 1'b1;
                     hold_cnt_d[i] = '0;
                  end else begin
                     hold_cnt_d[i] = hold_cnt_q[i] + CNT_W'(1);
                  end
               end
               default: begin
                  state_d[i]    = IDLE;
                  hold_cnt_d[i] = '0;
               end
            endcase
         end
      end
   end

   // Either button's debounced level vetoes the other's pulses; both FSMs keep running.
   always_comb begin
      pulse_d[0] = emit_s[0] & ~level_q[1] & en;
      pulse_d[1] = emit_s[1] & ~level_q[0] & en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 2'b00;
         sync2_q    <= 2'b00;
         tick_cnt_q <= '0;
         level_q    <= 2'b00;
         pulse_q    <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            db_cnt_q[i]   <= '0;
            hold_cnt_q[i] <= '0;
            state_q[i]    <= IDLE;
         end
      end else begin
         sync1_q    <= raw_s;
         sync2_q    <= sync1_q;
         tick_cnt_q <= tick_cnt_d;
         level_q    <= level_d;
         pulse_q    <= pulse_d;
         for (int i = 0; i < 2; i++) begin
            db_cnt_q[i]   <= db_cnt_d[i];
            hold_cnt_q[i] <= hold_cnt_d[i];
            state_q[i]    <= state_d[i];
         end
      end
   end

   assign inc_level = level_q[0];
   assign dec_level = level_q[1];
   assign inc_pulse = pulse_q[0];
   assign dec_pulse = pulse_q[1];

endmodule

// File: tb/tb_pwm_button_conditioner.sv
// Directed bench for pwm_button_conditioner with default parameters (tick every 4 clk,
// ticks land on the clock edges numbered as multiples of 4 after each reset release).
module tb_pwm_button_conditioner;

   typedef struct {
      logic rst_n, en, inc, dec;
      logic el, dl, ip, dp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic btn_inc_raw = 1'b0;
   logic btn_dec_raw = 1'b0;
   logic inc_level, dec_level, inc_pulse, dec_pulse;

   int checks_total = 0;
   int checks_pass  = 0;
   int k = 0;
   vec_t vecs [19];

   pwm_button_conditioner dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .btn_inc_raw(btn_inc_raw), .btn_dec_raw(btn_dec_raw),
      .inc_level(inc_level), .dec_level(dec_level),
      .inc_pulse(inc_pulse), .dec_pulse(dec_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      checks_total++;
      if (act === exp) checks_pass++;
      else $display("FAIL %s at cycle %0d: got %b expected %b", name, k, act, exp);
   endtask

   task automatic check4(input logic el, input logic dl, input logic ip, input logic dp);
      chk("inc_level", inc_level, el);
      chk("dec_level", dec_level, dl);
      chk("inc_pulse", inc_pulse, ip);
      chk("dec_pulse", dec_pulse, dp);
   endtask

   // Drive inputs on the falling edge, let one rising edge pass, sample on the next fall.
   task automatic step(input logic r, input logic e, input logic bi, input logic bd);
      rst_n = r; en = e; btn_inc_raw = bi; btn_dec_raw = bd;
      @(posedge clk);
      @(negedge clk);
      k++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = vecs[0];
      vecs[2] = vecs[0];
      for (int r = 3; r < 19; r++) begin
         int kk;
         kk = r - 2;
         vecs[r] = '{1'b1, 1'b1, 1'b1, 1'b0, (kk >= 12), 1'b0, (kk == 13), 1'b0};
      end

      repeat (3) @(negedge clk);
      check4(1'b0, 1'b0, 1'b0, 1'b0);

      // Glitch spanning two ticks leaves level low; a later press needs the full three ticks.
      for (int c = 1; c <= 34; c++) begin
         step(1'b1, 1'b1, (c <= 6) || (c >= 21), 1'b0);
         check4(k >= 32, 1'b0, k == 33, 1'b0);
      end

      // Reset mid-hold with both buttons high, then a fresh press of inc only.
      for (int r = 0; r < 19; r++) begin
         step(vecs[r].rst_n, vecs[r].en, vecs[r].inc, vecs[r].dec);
         if (!vecs[r].rst_n) k = 0;
         check4(vecs[r].el, vecs[r].dl, vecs[r].ip, vecs[r].dp);
      end

      // Hold inc: repeat delay, repeat cadence, then release before the next would-be pulse.
      for (int c = 17; c <= 90; c++) begin
         step(1'b1, 1'b1, c <= 60, 1'b0);
         check4(k < 72, 1'b0, (k == 44) || (k == 52) || (k == 60) || (k == 68), 1'b0);
      end

      // Conflict: both held suppresses pulses; releasing inc resumes the dec cadence.
      for (int c = 91; c <= 204; c++) begin
         step(1'b1, 1'b1, (c <= 140), (c >= 113) && (c <= 184));
         check4((k >= 104) && (k < 152), (k >= 124) && (k < 196), k == 105,
                (k == 156) || (k == 164) || (k == 172) || (k == 180) ||
                (k == 188) || (k == 196));
      end

      // Enable dropped for 20 clk mid-HOLD shifts the remaining delay by exactly 20 clk.
      for (int c = 205; c <= 290; c++) begin
         step(1'b1, !((c >= 230) && (c <= 249)), 1'b1, 1'b0);
         check4(k >= 216, 1'b0,
                (k == 217) || (k == 268) || (k == 276) || (k == 284), 1'b0);
      end

      $display("%0d/%0d checks passed", checks_pass, checks_total);
      $finish;
   end

endmodule
